bk_adder_pipe: RTL and testbench

Parametrised, pipelined Brent-Kung prefix adder/subtractor with a valid/ready stream interface. It accepts one operand pair per cycle and returns the sum, or difference, with carry, signed-overflow and zero flags after a fixed three-stage latency. It stalls cleanly under downstream backpressure. It is the general-width arithmetic core for datapaths that previously used fixed 4-bit combinational prefix adders.

---
 rtl/bk_pkg.sv | 19 +
 rtl/bk_prefix_cell.sv | 16 +
 rtl/bk_adder_pipe.sv | 182 ++++++++++++++++++
 tb/tb_bk_adder_pipe.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bk_pkg.sv
// Shared constants and helpers for the Brent-Kung adder pipeline.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bk_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Ceiling log2 used to size the prefix tree depth.
  function automatic int clog2w(input int w);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < w) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bk_prefix_cell.sv
// Brent-Kung (G,P) combine operator: (G,P) o (G',P') = (G | P&G', P&P').
// Latency: purely combinational.
// Backpressure: none, no state.
module bk_prefix_cell (
  input  logic g_hi_i,
  input  logic p_hi_i,
  input  logic g_lo_i,
  input  logic p_lo_i,
  output logic g_o,
  output logic p_o
);

  assign g_o = g_hi_i | (p_hi_i & g_lo_i);
  assign p_o = p_hi_i & p_lo_i;

endmodule

// File: rtl/bk_adder_pipe.sv
// Pipelined Brent-Kung adder/subtractor with carry, signed-overflow and zero flags.
// Latency: three register stages; result is valid three cycles after the accept cycle.
// Backpressure: per-stage valid bits; any empty slot ahead of a stall keeps in_ready high.
module bk_adder_pipe
  import bk_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int L = clog2w(WIDTH);

  // ---------------- handshake ----------------
  logic v1_q, v2_q, v3_q;
  logic v1_d, v2_d, v3_d;
  logic rdy2, rdy3;
  logic ld1, ld2, ld3;

  // A stage may load when empty or when its occupant moves on this cycle.
  assign rdy3     = !v3_q | out_ready;
  assign rdy2     = !v2_q | rdy3;
  assign in_ready = !v1_q | rdy2;
  assign ld1      = in_valid & in_ready;
  assign ld2      = v1_q & rdy2;
  assign ld3      = v2_q & rdy3;

  assign v1_d = ld1 | (v1_q & !rdy2);
  assign v2_d = ld2 | (v2_q & !rdy3);
  assign v3_d = ld3 | (v3_q & !out_ready);

  // Stage occupancy bits; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
    end
  end

  // ---------------- S1: operand conditioning ----------------
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [WIDTH-1:0] p1_q, g1_q;
  logic             cin1_q, sa1_q, sb1_q;

  assign b_eff   = (in_sub == OP_SUB) ? ~in_b : in_b;
  assign cin_eff = (in_sub == OP_SUB) ? 1'b1 : in_cin;

  // Capture bitwise propagate/generate, carry-in and operand signs.
  always_ff @(posedge clk) begin
    if (ld1) begin
      p1_q   <= in_a ^ b_eff;
      g1_q   <= in_a & b_eff;
      cin1_q <= cin_eff;
      sa1_q  <= in_a[WIDTH-1];
      sb1_q  <= b_eff[WIDTH-1];
    end
  end

  // ---------------- S2: up-sweep ----------------
  // Level l combines position i with i-2^(l-1) wherever i+1 is a multiple of 2^l;
  // other positions pass their previous group through unchanged.
  for (genvar l = 0; l <= L; l++) begin : up
    logic [WIDTH-1:0] g, p;
    if (l == 0) begin : g_leaf
      assign g = g1_q;
      assign p = p1_q;
    end else begin : g_lvl
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (((i + 1) % (1 << l)) == 0) begin : g_cell
          bk_prefix_cell u_cell (
            .g_hi_i(up[l-1].g[i]),
            .p_hi_i(up[l-1].p[i]),
            .g_lo_i(up[l-1].g[i - (1 << (l - 1))]),
            .p_lo_i(up[l-1].p[i - (1 << (l - 1))]),
            .g_o   (g[i]),
            .p_o   (p[i])
          );
        end else begin : g_pass
          assign g[i] = up[l-1].g[i];
          assign p[i] = up[l-1].p[i];
        end
      end
    end
  end

  logic [WIDTH-1:0] p2_q, gg2_q, gp2_q;
  logic             cin2_q, sa2_q, sb2_q;

  // Hold the reduced group pairs plus bitwise P for the sum XOR.
  always_ff @(posedge clk) begin
    if (ld2) begin
      p2_q   <= p1_q;
      gg2_q  <= up[L].g;
      gp2_q  <= up[L].p;
      cin2_q <= cin1_q;
      sa2_q  <= sa1_q;
      sb2_q  <= sb1_q;
    end
  end

  // ---------------- S3: down-sweep and sum ----------------
  // Level l fills positions i with (i+1) mod 2^l == 2^(l-1), i >= 2^l, from the
  // finished prefix ending at the preceding multiple of 2^l.
  for (genvar l = 1; l <= L; l++) begin : dn
    logic [WIDTH-1:0] g, p;
    if (l == L) begin : g_top
      assign g = gg2_q;
      assign p = gp2_q;
    end else begin : g_lvl
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if ((((i + 1) % (1 << l)) == (1 << (l - 1))) && (i >= (1 << l))) begin : g_cell
          bk_prefix_cell u_cell (
            .g_hi_i(dn[l+1].g[i]),
            .p_hi_i(dn[l+1].p[i]),
            .g_lo_i(dn[l+1].g[((i + 1) >> l) * (1 << l) - 1]),
            .p_lo_i(dn[l+1].p[((i + 1) >> l) * (1 << l) - 1]),
            .g_o   (g[i]),
            .p_o   (p[i])
          );
        end else begin : g_pass
          assign g[i] = dn[l+1].g[i];
          assign p[i] = dn[l+1].p[i];
        end
      end
    end
  end

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d, ovf_d, zero_d;

  assign carry  = {dn[1].g | (dn[1].p & {WIDTH{cin2_q}}), cin2_q};
  assign sum_d  = p2_q ^ carry[WIDTH-1:0];
  assign cout_d = carry[WIDTH];
  // Same-sign operands producing an opposite-sign result is a signed overflow.
  assign ovf_d  = (sa2_q == sb2_q) & (sum_d[WIDTH-1] != sa2_q);
  assign zero_d = ~|sum_d;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q, zero_q;

  // Output registers; they only change when a new beat moves in, so data holds under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (ld3) begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign out_valid = v3_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_bk_adder_pipe.sv
// Self-checking bench for bk_adder_pipe: directed vectors, backpressure, reset, random sweep.
// Latency: expects results three cycles after the accept cycle.
// Backpressure: drives out_ready low for stall windows and random patterns.
module tb_bk_adder_pipe;

  localparam int W = 16;
  typedef logic [W+2:0] res_t;  // {cout, ovf, zero, sum}

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_cin, in_sub;
  logic [W-1:0] in_a, in_b;
  logic         out_valid, out_ready, out_cout, out_ovf, out_zero;
  logic [W-1:0] out_sum;

  bk_adder_pipe #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .in_sub   (in_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ovf  (out_ovf),
    .out_zero (out_zero)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   passed = 0;
  int   nin = 0;
  int   nout = 0;
  res_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Arithmetic reference: plain integer add/subtract on unsigned and signed views.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    longint ua, ub, sa, sb, u, t;
    logic [W-1:0] s;
    logic co, ov;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      u  = ua - ub;
      co = (ua >= ub);
      t  = sa - sb;
    end else begin
      u  = ua + ub + longint'(cin);
      co = (u >= (longint'(1) << W));
      t  = sa + sb + longint'(cin);
    end
    s  = u[W-1:0];
    ov = (t > ((longint'(1) << (W - 1)) - 1)) || (t < -(longint'(1) << (W - 1)));
    return {co, ov, (s == '0), s};
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b1, {(W-1){1'b0}}};
      3:       v = {1'b0, {(W-1){1'b1}}};
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  // Scoreboard: push on input handshake, pop and compare on output handshake,
  // and require held outputs across every stalled cycle.
  initial begin : compare
    logic stall_q;
    res_t held;
    res_t got;
    stall_q = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      got = {out_cout, out_ovf, out_zero, out_sum};
      if (rst) begin
        nin -= q.size();
        q.delete();
        stall_q = 1'b0;
      end else begin
        if (stall_q) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", got, held);
        end
        if (out_valid && out_ready) begin
          chk("out_beat_expected", (q.size() > 0), 1);
          if (q.size() > 0) begin
            chk("result", got, q.pop_front());
            nout++;
          end
        end
        if (in_valid && in_ready) begin
          q.push_back(model(in_a, in_b, in_cin, in_sub));
          nin++;
        end
        stall_q = out_valid && !out_ready;
        held    = got;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // One beat into an empty pipe; checks latency and literal result fields.
  task automatic send_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input logic [W-1:0] e_sum, input logic e_cout,
                          input logic e_ovf, input logic e_zero);
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub;
    @(negedge clk);
    chk("dir_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("dir_not_early", out_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("dir_out_valid", out_valid, 1);
    chk("dir_sum", out_sum, e_sum);
    chk("dir_cout", out_cout, e_cout);
    chk("dir_ovf", out_ovf, e_ovf);
    chk("dir_zero", out_zero, e_zero);
    @(posedge clk); #1;
  endtask

  initial begin : main
    int sent;
    int n0;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    out_ready = 1'b1;

    // Pin the reference model to hand-computed results.
    chk("model_add", model(16'h1234, 16'h4321, 1'b1, 1'b0), {3'b000, 16'h5556});
    chk("model_wrap", model(16'hFFFF, 16'h0001, 1'b0, 1'b0), {3'b101, 16'h0000});
    chk("model_ovf", model(16'h7FFF, 16'h0001, 1'b0, 1'b0), {3'b010, 16'h8000});
    chk("model_sub", model(16'h0005, 16'h0007, 1'b1, 1'b1), {3'b000, 16'hFFFE});

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_flags", {out_cout, out_ovf, out_zero}, 0);
    @(posedge clk); #1;

    send_one(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0);
    send_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    send_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    send_one(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    send_one(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    send_one(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    send_one(16'hABCD, 16'hABCD, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

    // Eight back-to-back beats with out_ready low for cycles 4..9.
    sent = 0;
    n0 = nout;
    for (int c = 0; c < 30; c++) begin
      in_valid  = (sent < 8);
      in_a      = W'(sent * 16'h2345 + 16'h0F0F);
      in_b      = W'(16'h7000 + sent * 16'h1111);
      in_cin    = sent[1];
      in_sub    = sent[0];
      out_ready = !(c >= 4 && c <= 9);
      @(negedge clk);
      if (c == 3) chk("bp_ready_c3", in_ready, 1);
      if (c == 4) begin
        chk("bp_ready_full", in_ready, 0);
        chk("bp_valid_full", out_valid, 1);
      end
      if (c == 9) chk("bp_ready_c9", in_ready, 0);
      if (c == 10) chk("bp_ready_resume", in_ready, 1);
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_sent", sent, 8);
    chk("bp_received", nout - n0, 8);

    // Fill three stages with out_ready low, then reset mid-stream.
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_a = W'(16'hAAA0 + c); in_b = 16'h1111; in_cin = 1'b0; in_sub = 1'b0;
      @(negedge clk);
      chk("fill_ready", in_ready, (c < 3));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_sum", out_sum, 0);
    n0 = nout;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_rst_no_stale", nout - n0, 0);

    // Random traffic with random backpressure.
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_a      = pick();
      in_b      = pick();
      in_cin    = 1'($urandom);
      in_sub    = 1'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("drain_empty", q.size(), 0);
    chk("in_out_count", nout, nin);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
